axi4_lite_req_arbiter: RTL
==========================

Name: axi4_lite_req_arbiter

Overview:
- Shares one AXI4-Lite master between NUM_REQ local requesters using round-robin arbitration.
- Accepts one transaction at a time through a valid/ready request port.
- Sequences the master through its START_READ/START_WRITE pulse, address and W_data inputs.
- Detects completion by monitoring the master's R and B channel handshakes, then returns read data and response to the winning requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDRESS, 2, address width; matches the master.
- DATA_WIDTH, 8, data width; matches the master.
- GRANT_W, $clog2(NUM_REQ), width of the grant index (derived).

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDRESS  packed addresses; requester i at [i*ADDRESS +: ADDRESS].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid, 0 for writes.
- rsp_err  out  1  RRESP or BRESP captured at completion.
- START_READ  out  1  to master.
- START_WRITE  out  1  to master.
- address  out  ADDRESS  to master.
- W_data  out  DATA_WIDTH  to master.
- rd_done  in  1  M_RVALID & M_RREADY.
- rd_data  in  DATA_WIDTH  M_RDATA.
- rd_resp  in  1  M_RRESP.
- wr_done  in  1  M_BVALID & M_BREADY.
- wr_resp  in  1  M_BRESP.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  GRANT_W  index of the current or last owner.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- Reset (async, ARESETN low): state = IDLE; rr pointer = NUM_REQ-1, so requester 0 has first priority. All outputs are 0: req_ready, rsp_valid, rsp_rdata, rsp_err, START_*, address, W_data, busy, grant_id.
- Reset mid-transaction: aborts, no response is returned, and outputs go to their reset values immediately. The master is reset by the same ARESETN.
- IDLE:
  - Winner = first i with req_valid[i], searching (ptr+1) mod NUM_REQ upward with wrap.
  - If a winner exists: req_ready[winner] = 1 combinationally in the same cycle. On that edge, capture addr, wdata and write flag; set grant_id = winner and ptr = winner; go to ISSUE.
  - No req_valid: stay in IDLE, req_ready = 0.
- ISSUE: exactly one cycle.
  - START_WRITE = 1 if the captured write flag is set, else START_READ = 1. Never both.
  - Go to WAIT.
- WAIT:
  - address and W_data hold the captured values for the whole transaction, ISSUE through RESP. The master drives its channels combinationally from them.
  - Read: on rd_done, capture rd_data into rsp_rdata and rd_resp into rsp_err; go to RESP.
  - Write: on wr_done, capture wr_resp into rsp_err and set rsp_rdata = 0; go to RESP.
  - The done signal of the wrong direction is ignored. There is no timeout; WAIT persists until completion.
- RESP: exactly one cycle.
  - rsp_valid[grant_id] = 1. Responses have no backpressure.
  - Go to IDLE. req_ready is 0 in this cycle.
- Latency and throughput:
  - Request accept to START pulse: 1 cycle.
  - Done to rsp_valid: 1 cycle.
  - Minimum time between accepts: 3 cycles plus bus time.
- rd_done or wr_done while in IDLE, ISSUE or RESP is ignored.
- A requester that drops req_valid before it is accepted loses its turn, with no side effects.
- Payload is sampled only at accept; later changes on req_* have no effect.
- rsp_rdata and rsp_err hold their values until the next completion.

Test Plan:
- Single read: reset, req_valid[0]=1, req_write[0]=0, req_addr=2'b10. Required: req_ready[0] in cycle 0, START_READ in cycle 1, address=2'b10. Model returns rd_done with rd_data=8'hA5, rd_resp=0. Required: rsp_valid[0] the next cycle with rsp_rdata=8'hA5, rsp_err=0.
- Single write: req 2 writes wdata=8'h3C to addr 1. Required: START_WRITE only; W_data=8'h3C held until wr_done. wr_resp=1 gives rsp_valid[2] with rsp_err=1 and rsp_rdata=0.
- Round-robin: all four req_valid held high, four back-to-back reads. Required grant order 0,1,2,3, then 0 again, each with one rsp_valid pulse to the matching requester.
- Wrong-direction and spurious done: wr_done during a read in WAIT gives no transition. rd_done in IDLE gives no rsp_valid. The real rd_done later completes normally.
- Reset mid-WAIT: ARESETN low in WAIT forces all outputs to 0 asynchronously and no rsp_valid is issued. After release, req 3 is accepted and the pointer restarts so requester 0 would win a tie.
- Request withdrawal: req_valid[1] pulses for one cycle while req 0 is in WAIT. Required: req_ready[1] never asserts and no transaction is issued for requester 1.

Source files
------------

// File: rtl/axi4_lite_req_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master between NUM_REQ requesters.
// One transaction at a time: accept, pulse START, wait for R/B handshake, return response.
module axi4_lite_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDRESS    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int GRANT_W    = $clog2(NUM_REQ)
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDRESS-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          START_READ,
    output logic                          START_WRITE,
    output logic [ADDRESS-1:0]            address,
    output logic [DATA_WIDTH-1:0]         W_data,
    input  logic                          rd_done,
    input  logic [DATA_WIDTH-1:0]         rd_data,
    input  logic                          rd_resp,
    input  logic                          wr_done,
    input  logic                          wr_resp,
    output logic                          busy,
    output logic [GRANT_W-1:0]            grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [GRANT_W-1:0]      ptr_q;
    logic [GRANT_W-1:0]      grant_q;
    logic                    write_q;
    logic [ADDRESS-1:0]      addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic [NUM_REQ-1:0]      rsp_valid_q;
    logic                    start_rd_q;
    logic                    start_wr_q;
    logic                    busy_q;

    logic                    win_found_s;
    logic [GRANT_W-1:0]      win_idx_s;
    logic [GRANT_W-1:0]      cand_s;
    logic [NUM_REQ-1:0]      req_ready_s;

    // Round-robin search starting just after the last owner, wrapping around.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s      = GRANT_W'((int'(ptr_q) + k) % NUM_REQ);
            win_idx_s   = (!win_found_s && req_valid[cand_s]) ? cand_s : win_idx_s;
            win_found_s = win_found_s | req_valid[cand_s];
        end
    end

    // Accept is combinational in IDLE and forced low while reset is asserted.
    always_comb begin
        req_ready_s = '0;
        if ((state_q == ST_IDLE) && win_found_s && ARESETN) begin
            req_ready_s[win_idx_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    // Transaction sequencer with registered master-side and response outputs.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            ptr_q       <= GRANT_W'(NUM_REQ - 1);
            grant_q     <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= '0;
            start_rd_q  <= 1'b0;
            start_wr_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            start_rd_q  <= 1'b0;
            start_wr_q  <= 1'b0;
            rsp_valid_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (win_found_s) begin
                        write_q    <= req_write[win_idx_s];
                        addr_q     <= req_addr[win_idx_s*ADDRESS +: ADDRESS];
                        wdata_q    <= req_wdata[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
                        grant_q    <= win_idx_s;
                        ptr_q      <= win_idx_s;
                        start_rd_q <= ~req_write[win_idx_s];
                        start_wr_q <= req_write[win_idx_s];
                        busy_q     <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end else begin
                        state_q    <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Only the done of the issued direction can complete the transfer.
                    if (write_q && wr_done) begin
                        rdata_q     <= '0;
                        err_q       <= wr_resp;
                        rsp_valid_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
                        state_q     <= ST_RESP;
                    end else if (!write_q && rd_done) begin
                        rdata_q     <= rd_data;
                        err_q       <= rd_resp;
                        rsp_valid_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
                        state_q     <= ST_RESP;
                    end else begin
                        state_q     <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_s;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign START_READ  = start_rd_q;
    assign START_WRITE = start_wr_q;
    assign address     = addr_q;
    assign W_data      = wdata_q;
    assign busy        = busy_q;
    assign grant_id    = grant_q;

endmodule
